// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//
// Far-end receiver for a serial frame made of DATA_W data bits (LSB first)
// followed by one parity bit. The data bits are collected into a shift
// register while a running XOR of them is kept. When the parity bit arrives,
// the block publishes the data word, the recomputed data parity and a
// parity-error flag, and pulses frame_done. An sof seen while a frame is in
// progress throws the partial frame away, pulses frame_abort and starts a new
// frame with that bit.
//
// Parameters:
//   DATA_W      number of data bits per frame (>= 1)
//   ODD_PARITY  0 = even parity (data + parity bit has an even number of ones)
//               1 = odd parity
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   asynchronous, active-high reset
//   bit_valid    in   qualifies bit_in and sof for this cycle
//   bit_in       in   serial data / parity bit
//   sof          in   start of frame; marks bit_in as data bit 0
//   data_out     out  data of the last completed frame (bit i = i-th bit)
//   data_par     out  XOR of data_out bits
//   parity_err   out  parity error flag of the last completed frame
//   frame_done   out  one-cycle pulse when a frame completes
//   frame_abort  out  one-cycle pulse when a frame in progress is restarted
//   busy         out  high while a frame is being collected
// -----------------------------------------------------------------------------
`default_nettype none

module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              data_par,
    output logic              parity_err,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              busy
);

    // Counter wide enough to hold DATA_W itself; it restarts on every sof,
    // so it can never wrap.
    localparam int CNT_W = (DATA_W < 1) ? 1 : $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    // Error flag: the data parity plus the received parity bit must match
    // the configured mode (even -> 0, odd -> 1); any difference is an error.
    function automatic logic parity_error(input logic run_par, input logic par_bit);
        return run_par ^ par_bit ^ ODD_BIT;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] shift_r;
    logic              run_par_r;

    logic [DATA_W-1:0] data_out_r;
    logic              data_par_r;
    logic              parity_err_r;
    logic              frame_done_r;
    logic              frame_abort_r;
    logic              busy_r;

    logic [DATA_W-1:0] first_word_s;
    logic [DATA_W-1:0] shift_next_s;

    // First word of a new frame: bit 0 from bit_in, all other positions cleared.
    always_comb begin
        first_word_s    = '0;
        first_word_s[0] = bit_in;
    end

    // Shift register with bit_in written into the position given by the count.
    always_comb begin
        shift_next_s = shift_r;
        for (int i = 0; i < DATA_W; i++) begin
            if (count_r == CNT_W'(i)) begin
                shift_next_s[i] = bit_in;
            end else begin
                shift_next_s[i] = shift_r[i];
            end
        end
    end

    // Frame FSM together with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            count_r       <= '0;
            shift_r       <= '0;
            run_par_r     <= 1'b0;
            data_out_r    <= '0;
            data_par_r    <= 1'b0;
            parity_err_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_abort_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-asserted below.
            frame_done_r  <= 1'b0;
            frame_abort_r <= 1'b0;

            if (bit_valid) begin
                if (sof) begin
                    // A new frame starts in every state; an unfinished one
                    // is dropped without touching the published results.
                    frame_abort_r <= (state_r != ST_IDLE);
                    shift_r       <= first_word_s;
                    run_par_r     <= bit_in;
                    count_r       <= CNT_ONE;
                    busy_r        <= 1'b1;
                    if (DATA_W == 1) begin
                        state_r <= ST_PAR;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            // Stray bits outside a frame are ignored.
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                        ST_DATA: begin
                            shift_r   <= shift_next_s;
                            run_par_r <= run_par_r ^ bit_in;
                            count_r   <= count_r + CNT_ONE;
                            busy_r    <= 1'b1;
                            if (count_r == LAST_IDX) begin
                                state_r <= ST_PAR;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                        ST_PAR: begin
                            data_out_r   <= shift_r;
                            data_par_r   <= run_par_r;
                            parity_err_r <= parity_error(run_par_r, bit_in);
                            frame_done_r <= 1'b1;
                            busy_r       <= 1'b0;
                            state_r      <= ST_IDLE;
                        end
                        default: begin
                            // Unreachable encoding: recover to a clean idle.
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    endcase
                end
            end else begin
                // No accepted bit: everything holds, there is no timeout.
                state_r <= state_r;
            end
        end
    end

    assign data_out    = data_out_r;
    assign data_par    = data_par_r;
    assign parity_err  = parity_err_r;
    assign frame_done  = frame_done_r;
    assign frame_abort = frame_abort_r;
    assign busy        = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
// -----------------------------------------------------------------------------
// Directed testbench for serial_parity_checker. Two instances share the same
// stimulus: u_dut in even mode, u_odd in odd mode. Inputs change on the
// falling edge, outputs are read on the falling edge, and a pulse monitor
// samples 2 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_parity_checker;

    logic       clk;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic       sof;

    logic [7:0] data_out;
    logic       data_par;
    logic       parity_err;
    logic       frame_done;
    logic       frame_abort;
    logic       busy;

    logic [7:0] o_data_out;
    logic       o_data_par;
    logic       o_parity_err;
    logic       o_frame_done;
    logic       o_frame_abort;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    int cyc        = 0;
    int done_cnt   = 0;
    int abort_cnt  = 0;
    int done_cyc   = 0;
    int done_cyc_p = 0;
    logic [7:0] done_data_p = 8'h00;
    logic       done_err_p  = 1'b0;
    logic [7:0] done_data   = 8'h00;
    logic       done_err    = 1'b0;

    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .sof         (sof),
        .data_out    (data_out),
        .data_par    (data_par),
        .parity_err  (parity_err),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .sof         (sof),
        .data_out    (o_data_out),
        .data_par    (o_data_par),
        .parity_err  (o_parity_err),
        .frame_done  (o_frame_done),
        .frame_abort (o_frame_abort),
        .busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor for the even-mode instance, sampled away from both edges.
    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (frame_done) begin
            done_cnt    = done_cnt + 1;
            done_cyc_p  = done_cyc;
            done_cyc    = cyc;
            done_data_p = done_data;
            done_err_p  = done_err;
            done_data   = data_out;
            done_err    = parity_err;
        end
        if (frame_abort) begin
            abort_cnt = abort_cnt + 1;
        end
        if (frame_done && frame_abort) begin
            failures = failures + 1;
            $display("FAIL done_and_abort: both pulses high at cycle %0d", cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus, applied at the falling edge.
    task automatic put(input logic v, input logic b, input logic s);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        sof       = s;
    endtask

    // Eight data bits LSB first, sof on bit 0, optional 1..3 cycle stalls.
    task automatic send_data(input logic [7:0] d, input logic stall);
        for (int i = 0; i < 8; i++) begin
            put(1'b1, d[i], (i == 0));
            if (stall) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    put(1'b0, 1'b0, 1'b0);
                end
            end
        end
    endtask

    int done_base;

    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        sof       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        put(1'b0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        check_eq("rst_data_out",    32'(data_out),    32'h00);
        check_eq("rst_data_par",    32'(data_par),    32'h0);
        check_eq("rst_parity_err",  32'(parity_err),  32'h0);
        check_eq("rst_frame_done",  32'(frame_done),  32'h0);
        check_eq("rst_frame_abort", 32'(frame_abort), 32'h0);
        check_eq("rst_busy",        32'(busy),        32'h0);
        check_eq("rst_odd_err",     32'(o_parity_err), 32'h0);

        // Partial frame then asynchronous reset mid-cycle.
        put(1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b0, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        check_eq("partial_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1 check_eq("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 1'b1, 1'b0);
        end
        put(1'b0, 1'b0, 1'b0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("rst_lost_busy",  32'(busy),      32'h0);
        check_eq("rst_lost_done",  32'(done_cnt),  32'd0);
        check_eq("rst_lost_abort", 32'(abort_cnt), 32'd0);

        // ---------------- good frame 0xA5 ----------------
        send_data(8'hA5, 1'b0);
        put(1'b1, 1'b0, 1'b0);
        check_eq("good_busy_pre", 32'(busy),       32'h1);
        check_eq("good_done_pre", 32'(frame_done), 32'h0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("good_done",     32'(frame_done), 32'h1);
        check_eq("good_data",     32'(data_out),   32'hA5);
        check_eq("good_par",      32'(data_par),   32'h0);
        check_eq("good_err",      32'(parity_err), 32'h0);
        check_eq("good_busy",     32'(busy),       32'h0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("good_done_pulse", 32'(frame_done), 32'h0);
        check_eq("good_data_hold",  32'(data_out),   32'hA5);

        // ---------------- bad frame 0x07 with stalls ----------------
        done_base = done_cnt;
        send_data(8'h07, 1'b1);
        put(1'b1, 1'b0, 1'b0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("bad_done", 32'(frame_done), 32'h1);
        check_eq("bad_data", 32'(data_out),   32'h07);
        check_eq("bad_par",  32'(data_par),   32'h1);
        check_eq("bad_err",  32'(parity_err), 32'h1);
        repeat (3) put(1'b0, 1'b0, 1'b0);
        check_eq("bad_done_count", 32'(done_cnt - done_base), 32'd1);

        // ---------------- restart with 0x3C ----------------
        done_base = done_cnt;
        put(1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b0, 1'b1);          // sof, bit 0 of 0x3C
        put(1'b1, 1'b0, 1'b0);          // bit 1 of 0x3C
        check_eq("rst_abort_pulse", 32'(frame_abort), 32'h1);
        check_eq("rst_abort_nodone", 32'(frame_done), 32'h0);
        check_eq("rst_busy_kept",   32'(busy),        32'h1);
        check_eq("rst_hold_data",   32'(data_out),    32'h07);
        check_eq("rst_hold_err",    32'(parity_err),  32'h1);
        for (int i = 2; i < 8; i++) begin
            put(1'b1, (8'h3C >> i) & 8'h01, 1'b0);
            check_eq("rst_abort_once", 32'(frame_abort), 32'h0);
        end
        put(1'b1, 1'b0, 1'b0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("rst_done",  32'(frame_done), 32'h1);
        check_eq("rst_data",  32'(data_out),   32'h3C);
        check_eq("rst_err",   32'(parity_err), 32'h0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("rst_done_count",  32'(done_cnt - done_base), 32'd1);
        check_eq("rst_abort_count", 32'(abort_cnt),            32'd1);

        // ---------------- back-to-back 0xFF / 0x01 ----------------
        done_base = done_cnt;
        send_data(8'hFF, 1'b0);
        put(1'b1, 1'b0, 1'b0);
        send_data(8'h01, 1'b0);
        put(1'b1, 1'b0, 1'b0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("b2b_done", 32'(frame_done), 32'h1);
        check_eq("b2b_data", 32'(data_out),   32'h01);
        check_eq("b2b_par",  32'(data_par),   32'h1);
        check_eq("b2b_err",  32'(parity_err), 32'h1);
        put(1'b0, 1'b0, 1'b0);
        check_eq("b2b_done_count", 32'(done_cnt - done_base), 32'd2);
        check_eq("b2b_spacing",    32'(done_cyc - done_cyc_p), 32'd9);
        check_eq("b2b_first_data", 32'(done_data_p), 32'hFF);
        check_eq("b2b_first_err",  32'(done_err_p),  32'h0);

        // ---------------- odd mode: 0x00 with parity 1, then 0 ----------------
        send_data(8'h00, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("odd_p1_done", 32'(o_frame_done), 32'h1);
        check_eq("odd_p1_err",  32'(o_parity_err), 32'h0);
        check_eq("even_p1_err", 32'(parity_err),   32'h1);
        send_data(8'h00, 1'b0);
        put(1'b1, 1'b0, 1'b0);
        put(1'b0, 1'b0, 1'b0);
        check_eq("odd_p0_err",  32'(o_parity_err), 32'h1);
        check_eq("odd_p0_data", 32'(o_data_out),   32'h00);
        check_eq("even_p0_err", 32'(parity_err),   32'h0);

        repeat (2) put(1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
